// File: rtl/btb_write_scheduler.sv
// -----------------------------------------------------------------------------
// btb_write_scheduler
// Owns the single write port of the BTB storage array. It does three jobs:
//   * clears every entry after reset (INIT_SWEEP),
//   * queues resolved control-transfer updates from EX in a small FIFO and
//     writes them one per granted cycle (IDLE),
//   * runs a full invalidate sweep when inv_req is seen in IDLE (INV_SWEEP).
// It also gates fetch-side lookups while the table is being cleared.
//
// Ports
//   clk         in   clock, all state changes on the rising edge
//   reset       in   asynchronous active-low reset
//   upd_valid   in   EX presents a resolved update
//   upd_pc      in   pc of the control-transfer instruction
//   upd_target  in   resolved target
//   upd_ready   out  update accepted on an edge with upd_valid && upd_ready
//   inv_req     in   full-table invalidate request (level)
//   btb_wr_ok   in   storage accepts a write this cycle
//   btb_we      out  write strobe
//   btb_idx     out  entry index being written
//   btb_val     out  valid bit to write
//   btb_tag     out  tag to write
//   btb_target  out  target to write
//   lookup_en   out  fetch may use BTB predictions
//   inv_done    out  one-cycle registered pulse after a sweep completes
// -----------------------------------------------------------------------------
module btb_write_scheduler #(
    parameter  int ENTRY_BIT   = 5,
    parameter  int QUEUE_DEPTH = 2,
    localparam int TAG_BIT     = 30 - ENTRY_BIT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic [31:0]          upd_target,
    output logic                 upd_ready,
    input  logic                 inv_req,
    input  logic                 btb_wr_ok,
    output logic                 btb_we,
    output logic [ENTRY_BIT-1:0] btb_idx,
    output logic                 btb_val,
    output logic [TAG_BIT-1:0]   btb_tag,
    output logic [31:0]          btb_target,
    output logic                 lookup_en,
    output logic                 inv_done
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]     DEPTH_C = CNT_W'(QUEUE_DEPTH);
    localparam logic [ENTRY_BIT-1:0] IDX_MAX = {ENTRY_BIT{1'b1}};

    typedef enum logic [1:0] {
        ST_INIT_SWEEP = 2'b00,
        ST_IDLE       = 2'b01,
        ST_INV_SWEEP  = 2'b10
    } state_e;

    state_e               state_q, state_d;
    logic [ENTRY_BIT-1:0] sweep_cnt_q, sweep_cnt_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 inv_done_q, inv_done_d;

    logic [31:0]          pc_mem_q  [QUEUE_DEPTH];
    logic [31:0]          tgt_mem_q [QUEUE_DEPTH];

    logic                 fifo_ne_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 coalesce_s;
    logic                 fifo_wr_s;
    logic [PTR_W-1:0]     tail_ptr_s;

    assign inv_done = inv_done_q;

    // Next-state, FIFO bookkeeping and write-port outputs
    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        inv_done_d  = 1'b0;
        upd_ready   = 1'b0;
        lookup_en   = 1'b0;
        btb_we      = 1'b0;
        btb_idx     = '0;
        btb_val     = 1'b0;
        btb_tag     = '0;
        btb_target  = 32'h0000_0000;
        pop_s       = 1'b0;
        push_s      = 1'b0;
        coalesce_s  = 1'b0;
        fifo_wr_s   = 1'b0;
        fifo_ne_s   = (count_q != '0);
        tail_ptr_s  = wr_ptr_q - PTR_W'(1);

        if (reset == 1'b0) begin
            // Held in reset: every strobe stays low, flops are being cleared.
            state_d = ST_INIT_SWEEP;
        end else begin
            case (state_q)
                ST_INIT_SWEEP, ST_INV_SWEEP: begin
                    btb_idx = sweep_cnt_q;
                    btb_we  = btb_wr_ok;
                    if (btb_wr_ok) begin
                        if (sweep_cnt_q == IDX_MAX) begin
                            state_d     = ST_IDLE;
                            sweep_cnt_d = '0;
                            inv_done_d  = 1'b1;
                        end else begin
                            sweep_cnt_d = sweep_cnt_q + ENTRY_BIT'(1);
                        end
                    end else begin
                        sweep_cnt_d = sweep_cnt_q;
                    end
                end
                ST_IDLE: begin
                    lookup_en = 1'b1;
                    if (inv_req) begin
                        // Queued updates describe the old table contents; drop them.
                        state_d     = ST_INV_SWEEP;
                        sweep_cnt_d = '0;
                        wr_ptr_d    = '0;
                        rd_ptr_d    = '0;
                        count_d     = '0;
                    end else begin
                        upd_ready = (count_q < DEPTH_C);
                        if (fifo_ne_s) begin
                            btb_idx    = pc_mem_q[rd_ptr_q][2+ENTRY_BIT-1:2];
                            btb_tag    = pc_mem_q[rd_ptr_q][31:2+ENTRY_BIT];
                            btb_target = tgt_mem_q[rd_ptr_q];
                            btb_val    = 1'b1;
                            btb_we     = btb_wr_ok;
                            pop_s      = btb_wr_ok;
                        end else begin
                            pop_s = 1'b0;
                        end
                        push_s = upd_valid && upd_ready;
                        // Same pc as the tail: refresh its target, unless the tail
                        // is leaving this edge (then it must be a fresh entry).
                        coalesce_s = push_s && fifo_ne_s
                                     && (pc_mem_q[tail_ptr_s] == upd_pc)
                                     && !(pop_s && (count_q == CNT_W'(1)));
                        fifo_wr_s  = push_s && !coalesce_s;
                        if (fifo_wr_s) begin
                            wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        end else begin
                            wr_ptr_d = wr_ptr_q;
                        end
                        if (pop_s) begin
                            rd_ptr_d = rd_ptr_q + PTR_W'(1);
                        end else begin
                            rd_ptr_d = rd_ptr_q;
                        end
                        count_d = count_q + CNT_W'(fifo_wr_s) - CNT_W'(pop_s);
                    end
                end
                default: begin
                    state_d     = ST_INIT_SWEEP;
                    sweep_cnt_d = '0;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    count_d     = '0;
                end
            endcase
        end
    end

    // State machine, sweep counter, FIFO pointers and inv_done register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_INIT_SWEEP;
            sweep_cnt_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            inv_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            inv_done_q  <= inv_done_d;
        end
    end

    // FIFO payload storage; validity is tracked by the pointers/count
    always_ff @(posedge clk) begin
        if (fifo_wr_s) begin
            pc_mem_q[wr_ptr_q]  <= upd_pc;
            tgt_mem_q[wr_ptr_q] <= upd_target;
        end else if (coalesce_s) begin
            tgt_mem_q[tail_ptr_s] <= upd_target;
        end
    end

endmodule

// File: tb/tb_btb_write_scheduler.sv
// -----------------------------------------------------------------------------
// tb_btb_write_scheduler
// Drives directed scenarios followed by random traffic. A behavioural model
// (pending-update queue, sweep index) predicts handshake outputs and the
// sequence of storage writes; predicted writes go to a scoreboard queue that a
// separate monitor pops whenever the DUT strobes btb_we.
// -----------------------------------------------------------------------------
module tb_btb_write_scheduler;

    localparam int EB   = 5;
    localparam int QD   = 2;
    localparam int NENT = 1 << EB;

    logic        clk = 1'b0;
    logic        reset;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_ready;
    logic        inv_req;
    logic        btb_wr_ok;
    logic        btb_we;
    logic [4:0]  btb_idx;
    logic        btb_val;
    logic [24:0] btb_tag;
    logic [31:0] btb_target;
    logic        lookup_en;
    logic        inv_done;

    btb_write_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_ready  (upd_ready),
        .inv_req    (inv_req),
        .btb_wr_ok  (btb_wr_ok),
        .btb_we     (btb_we),
        .btb_idx    (btb_idx),
        .btb_val    (btb_val),
        .btb_tag    (btb_tag),
        .btb_target (btb_target),
        .lookup_en  (lookup_en),
        .inv_done   (inv_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tgt;
    } upd_t;

    typedef struct packed {
        logic [4:0]  idx;
        logic        val;
        logic [24:0] tag;
        logic [31:0] tgt;
    } wr_t;

    upd_t pend[$];
    wr_t  sb[$];
    int   errors = 0;
    int   checks = 0;

    bit   m_sweep = 1'b1;
    int   m_sidx  = 0;
    bit   m_done  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every storage write against the scoreboard head.
    initial begin
        wr_t act;
        wr_t exp;
        forever begin
            @(negedge clk);
            #2;
            if (btb_we === 1'b1) begin
                act.idx = btb_idx;
                act.val = btb_val;
                act.tag = btb_tag;
                act.tgt = btb_target;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL btb_write: unexpected write %0h, none expected", act);
                end else begin
                    exp = sb.pop_front();
                    check("btb_write", 64'(act), 64'(exp));
                end
            end
        end
    end

    // One clock cycle: drive inputs, predict, check, then advance the model.
    task automatic cycle(input bit rst, input bit v, input logic [31:0] pc,
                         input logic [31:0] tgt, input bit inv, input bit wr);
        bit   e_ready, e_lookup, e_we, e_done, popped, accepted;
        wr_t  rec;
        upd_t u;
        @(negedge clk);
        reset      = rst;
        upd_valid  = v;
        upd_pc     = pc;
        upd_target = tgt;
        inv_req    = inv;
        btb_wr_ok  = wr;
        #1;
        e_ready = 1'b0; e_lookup = 1'b0; e_we = 1'b0; e_done = 1'b0;
        rec = '0;
        if (rst) begin
            e_done   = m_done;
            e_lookup = !m_sweep;
            if (m_sweep) begin
                e_we    = wr;
                rec.idx = 5'(m_sidx);
            end else if (!inv) begin
                e_ready = (pend.size() < QD);
                if (pend.size() > 0) begin
                    e_we    = wr;
                    rec.idx = 5'((pend[0].pc >> 2) & 32'd31);
                    rec.val = 1'b1;
                    rec.tag = 25'(pend[0].pc >> 7);
                    rec.tgt = pend[0].tgt;
                end
            end
        end
        check("upd_ready", 64'(upd_ready), 64'(e_ready));
        check("lookup_en", 64'(lookup_en), 64'(e_lookup));
        check("inv_done",  64'(inv_done),  64'(e_done));
        check("btb_we",    64'(btb_we),    64'(e_we));
        if (e_we) sb.push_back(rec);
        @(posedge clk);
        if (!rst) begin
            m_sweep = 1'b1; m_sidx = 0; m_done = 1'b0;
            pend.delete();
        end else begin
            m_done = 1'b0;
            if (m_sweep) begin
                if (wr) begin
                    if (m_sidx == NENT - 1) begin
                        m_sweep = 1'b0; m_sidx = 0; m_done = 1'b1;
                    end else begin
                        m_sidx++;
                    end
                end
            end else if (inv) begin
                pend.delete();
                m_sweep = 1'b1;
                m_sidx  = 0;
            end else begin
                popped   = e_we;
                accepted = v && e_ready;
                if (accepted) begin
                    if (pend.size() > 0 && pend[pend.size()-1].pc == pc
                        && !(popped && pend.size() == 1)) begin
                        pend[pend.size()-1].tgt = tgt;
                    end else begin
                        u.pc  = pc;
                        u.tgt = tgt;
                        pend.push_back(u);
                    end
                end
                if (popped) void'(pend.pop_front());
            end
        end
    endtask

    task automatic idle(input int n, input bit wr);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, wr);
    endtask

    logic [31:0] pool [4] = '{32'h0000_0010, 32'h0000_0020, 32'h1234_5678, 32'hABCD_0010};

    initial begin
        reset = 1'b0; upd_valid = 1'b0; upd_pc = 32'h0; upd_target = 32'h0;
        inv_req = 1'b0; btb_wr_ok = 1'b0;

        // Power-up clear sweep
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        idle(34, 1'b1);

        // Single update, written the cycle after acceptance
        cycle(1'b1, 1'b1, 32'h0000_0040, 32'h0000_0100, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Fill the queue while storage stalls, then drain
        cycle(1'b1, 1'b1, 32'h0000_0010, 32'h0000_0011, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h0000_0020, 32'h0000_0022, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h0000_0030, 32'h0000_0033, 1'b0, 1'b0);
        idle(4, 1'b1);

        // Coalescing into the tail
        cycle(1'b1, 1'b1, 32'h0000_0010, 32'h0000_0080, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h0000_0010, 32'h0000_0090, 1'b0, 1'b0);
        idle(3, 1'b1);

        // Invalidate with updates queued; updates offered during the sweep
        cycle(1'b1, 1'b1, 32'h0000_0010, 32'h0000_0111, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h0000_0020, 32'h0000_0222, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 32'h0000_0044, 32'h0000_0444, 1'b1, 1'b1);
        idle(3, 1'b1);

        // Reset in the middle of an invalidate sweep at index 12
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        idle(12, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        idle(34, 1'b1);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 299) != 0), 1'($urandom_range(0, 1)),
                  pool[$urandom_range(0, 3)], $urandom,
                  ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0));
        end
        idle(40, 1'b1);

        @(negedge clk);
        #3;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
